watch_set_ctrl: RTL and testbench

- Front-end controller for the hh:mm:ss timekeeper datapath.
- Debounces the raw mode and set buttons, then sequences the edit modes RUN → SET_H → SET_M → SET_S → RUN.
- Issues clamped single-cycle load commands into the timekeeper and freezes timekeeping while editing.
- Drives per-field blink blanking for the 7-segment display, and returns to RUN automatically after an inactivity timeout.

---
 rtl/watch_pkg.sv | 14 +
 rtl/btn_debounce.sv | 44 ++++
 rtl/watch_set_ctrl.sv | 123 ++++++++++++
 tb/tb_watch_set_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// Shared types and limits for the watch front-end and the timekeeper datapath.
package watch_pkg;

    typedef enum logic [1:0] {
        MODE_RUN   = 2'd0,
        MODE_SET_H = 2'd1,
        MODE_SET_M = 2'd2,
        MODE_SET_S = 2'd3
    } watch_mode_t;

    localparam logic [5:0] MAX_HOUR    = 6'd23;
    localparam logic [5:0] MAX_MIN_SEC = 6'd59;

endpackage

// File: rtl/btn_debounce.sv
// Synchronizes a raw button, accepts a new level after DEBOUNCE_CYCLES stable
// cycles and emits a one-cycle pulse on each accepted press.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_p0;
    logic          sync_p1;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            cnt     <= '0;
            level   <= 1'b0;
            press   <= 1'b0;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
            press   <= 1'b0;
            // cnt counts consecutive cycles the synchronized input disagrees with level
            if (sync_p1 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sync_p1;
                press <= sync_p1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/watch_set_ctrl.sv
// Edit-mode sequencer for the hh:mm:ss timekeeper: debounced buttons, clamped
// load commands, display blink blanking and inactivity return to RUN.
module watch_set_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int TIMEOUT_S       = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_btn,
    input  logic       set_btn,
    input  logic [5:0] val,
    input  logic       tick_1hz,
    output logic [1:0] mode,
    output logic       run_en,
    output logic       load_stb,
    output logic [1:0] load_field,
    output logic [5:0] load_val,
    output logic       presc_clr,
    output logic [2:0] field_blank
);

    import watch_pkg::*;

    localparam int IW = $clog2(TIMEOUT_S + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_S - 1);
    localparam logic [IW-1:0] IDLE_SAT  = IW'(TIMEOUT_S);

    function automatic logic [5:0] clamp_val(watch_mode_t f, logic [5:0] v);
        logic [5:0] lim;
        lim = (f == MODE_SET_H) ? MAX_HOUR : MAX_MIN_SEC;
        return (v > lim) ? lim : v;
    endfunction

    watch_mode_t   state;
    watch_mode_t   next_state;
    logic [IW-1:0] idle_cnt;
    logic          blink_phase;
    logic          mode_press;
    logic          set_press;
    logic          mode_level;
    logic          set_level;
    logic          commit;
    logic          timed_out;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (mode_btn),
        .level   (mode_level),
        .press   (mode_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_db (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (set_btn),
        .level   (set_level),
        .press   (set_press)
    );

    // Any accepted press in the same cycle as the final tick keeps the edit alive
    always_comb begin
        next_state = state;
        commit     = 1'b0;
        timed_out  = 1'b0;
        if (mode_press) begin
            next_state = watch_mode_t'(state + 2'd1);
        end else if (state != MODE_RUN) begin
            if (set_press) begin
                commit = 1'b1;
            end else if (tick_1hz && idle_cnt == IDLE_LAST) begin
                timed_out  = 1'b1;
                next_state = MODE_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= MODE_RUN;
            idle_cnt    <= '0;
            blink_phase <= 1'b1;
            load_stb    <= 1'b0;
            load_field  <= 2'd0;
            load_val    <= 6'd0;
            presc_clr   <= 1'b0;
        end else begin
            state     <= next_state;
            load_stb  <= commit;
            presc_clr <= (next_state == MODE_RUN) && (state != MODE_RUN);
            if (commit) begin
                load_field <= state;
                load_val   <= clamp_val(state, val);
            end
            if (state == MODE_RUN || next_state != state || mode_press || set_press) begin
                idle_cnt <= '0;
            end else if (tick_1hz && idle_cnt != IDLE_SAT) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
            if (state == MODE_RUN || next_state != state) begin
                blink_phase <= 1'b1;
            end else if (tick_1hz) begin
                blink_phase <= ~blink_phase;
            end
        end
    end

    always_comb begin
        field_blank = 3'b000;
        if (!blink_phase) begin
            case (state)
                MODE_SET_H: field_blank = 3'b100;
                MODE_SET_M: field_blank = 3'b010;
                MODE_SET_S: field_blank = 3'b001;
                default:    field_blank = 3'b000;
            endcase
        end
    end

    assign mode   = state;
    assign run_en = (state == MODE_RUN);

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Directed bench for watch_set_ctrl with short debounce and timeout settings.
module tb_watch_set_ctrl;

    localparam int DB = 8;
    localparam int TO = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode_btn;
    logic       set_btn;
    logic [5:0] val;
    logic       tick_1hz;
    logic [1:0] mode;
    logic       run_en;
    logic       load_stb;
    logic [1:0] load_field;
    logic [5:0] load_val;
    logic       presc_clr;
    logic [2:0] field_blank;

    int n_cmp = 0;
    int n_err = 0;
    int stb_cnt = 0;
    int pc_cnt = 0;
    int stb_base;
    int pc_base;
    logic [1:0] last_field = 2'd0;
    logic [5:0] last_val = 6'd0;

    watch_set_ctrl #(.DEBOUNCE_CYCLES(DB), .TIMEOUT_S(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .mode_btn    (mode_btn),
        .set_btn     (set_btn),
        .val         (val),
        .tick_1hz    (tick_1hz),
        .mode        (mode),
        .run_en      (run_en),
        .load_stb    (load_stb),
        .load_field  (load_field),
        .load_val    (load_val),
        .presc_clr   (presc_clr),
        .field_blank (field_blank)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (load_stb === 1'b1) begin
            stb_cnt++;
            last_field = load_field;
            last_val   = load_val;
        end
        if (presc_clr === 1'b1) pc_cnt++;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Hold the button(s) long enough to be accepted, then release and let it settle.
    task automatic press(input bit m, input bit s);
        if (m) mode_btn = 1'b1;
        if (s) set_btn = 1'b1;
        repeat (DB + 4) @(negedge clk);
        mode_btn = 1'b0;
        set_btn  = 1'b0;
        repeat (DB + 4) @(negedge clk);
    endtask

    task automatic tick();
        tick_1hz = 1'b1;
        @(negedge clk);
        tick_1hz = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; mode_btn = 1'b0; set_btn = 1'b0; val = 6'd0; tick_1hz = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mode", 8'(mode), 8'd0);
        check("rst_run_en", 8'(run_en), 8'd1);
        check("rst_load_stb", 8'(load_stb), 8'd0);
        check("rst_load_field", 8'(load_field), 8'd0);
        check("rst_load_val", 8'(load_val), 8'd0);
        check("rst_presc_clr", 8'(presc_clr), 8'd0);
        check("rst_field_blank", 8'(field_blank), 8'd0);
        rst = 1'b0;
        @(negedge clk);

        // bounce: 12 toggles every 3 cycles, then a final clean rising edge
        for (int k = 0; k < 12; k++) begin
            mode_btn = ~mode_btn;
            repeat (3) @(negedge clk);
        end
        check("bounce_no_press", 8'(mode), 8'd0);
        mode_btn = 1'b1;
        repeat (2 + DB) @(negedge clk);
        check("bounce_mode_early", 8'(mode), 8'd0);
        @(negedge clk);
        check("bounce_mode_at_11", 8'(mode), 8'd1);
        check("seth_run_en", 8'(run_en), 8'd0);
        repeat (20) @(negedge clk);
        check("bounce_single_press", 8'(mode), 8'd1);
        mode_btn = 1'b0;
        repeat (DB + 4) @(negedge clk);

        // full mode cycle
        pc_base = pc_cnt;
        press(1, 0);
        check("cycle_mode2", 8'(mode), 8'd2);
        check("cycle_run_en2", 8'(run_en), 8'd0);
        press(1, 0);
        check("cycle_mode3", 8'(mode), 8'd3);
        check("cycle_run_en3", 8'(run_en), 8'd0);
        check("cycle_no_presc_yet", 8'(pc_cnt - pc_base), 8'd0);
        press(1, 0);
        check("cycle_mode0", 8'(mode), 8'd0);
        check("cycle_run_en0", 8'(run_en), 8'd1);
        check("cycle_presc_pulse", 8'(pc_cnt - pc_base), 8'd1);

        // clamps
        press(1, 0);
        val = 6'd45; stb_base = stb_cnt;
        press(0, 1);
        check("clamp_h_stb", 8'(stb_cnt - stb_base), 8'd1);
        check("clamp_h_field", 8'(last_field), 8'd1);
        check("clamp_h_val", 8'(last_val), 8'd23);
        check("clamp_h_mode", 8'(mode), 8'd1);
        press(1, 0);
        val = 6'd63; stb_base = stb_cnt;
        press(0, 1);
        check("clamp_m_stb", 8'(stb_cnt - stb_base), 8'd1);
        check("clamp_m_field", 8'(last_field), 8'd2);
        check("clamp_m_val", 8'(last_val), 8'd59);
        press(1, 0);
        val = 6'd17; stb_base = stb_cnt;
        press(0, 1);
        check("clamp_s_field", 8'(last_field), 8'd3);
        check("clamp_s_val", 8'(last_val), 8'd17);
        stb_base = stb_cnt;
        press(0, 1);
        check("repeat_commit_stb", 8'(stb_cnt - stb_base), 8'd1);
        press(1, 0);
        check("back_to_run", 8'(mode), 8'd0);

        // ignored and conflicting presses
        stb_base = stb_cnt;
        press(0, 1);
        check("run_set_ignored", 8'(stb_cnt - stb_base), 8'd0);
        press(1, 0);
        stb_base = stb_cnt;
        press(1, 1);
        check("conflict_mode", 8'(mode), 8'd2);
        check("conflict_no_stb", 8'(stb_cnt - stb_base), 8'd0);

        // timeout in SET_M
        pc_base = pc_cnt; stb_base = stb_cnt;
        tick();
        tick();
        check("to_still_setm", 8'(mode), 8'd2);
        tick();
        check("to_mode_run", 8'(mode), 8'd0);
        check("to_presc_pulse", 8'(pc_cnt - pc_base), 8'd1);
        check("to_no_stb", 8'(stb_cnt - stb_base), 8'd0);

        // a set press between ticks 2 and 3 restarts the idle count
        press(1, 0);
        press(1, 0);
        tick();
        tick();
        press(0, 1);
        tick();
        check("to_press_keeps_setm", 8'(mode), 8'd2);

        // blink in SET_S
        press(1, 0);
        check("blink_entry_mode", 8'(mode), 8'd3);
        check("blink_entry", 8'(field_blank), 8'b000);
        tick();
        check("blink_tick1", 8'(field_blank), 8'b001);
        tick();
        check("blink_tick2", 8'(field_blank), 8'b000);

        // reset mid-edit with a set press in flight
        stb_base = stb_cnt;
        set_btn = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst2_mode", 8'(mode), 8'd0);
        check("rst2_run_en", 8'(run_en), 8'd1);
        check("rst2_load_stb", 8'(load_stb), 8'd0);
        check("rst2_load_field", 8'(load_field), 8'd0);
        check("rst2_load_val", 8'(load_val), 8'd0);
        check("rst2_presc_clr", 8'(presc_clr), 8'd0);
        check("rst2_field_blank", 8'(field_blank), 8'd0);
        rst = 1'b0;
        repeat (DB + 6) @(negedge clk);
        set_btn = 1'b0;
        repeat (DB + 4) @(negedge clk);
        check("rst2_no_stb", 8'(stb_cnt - stb_base), 8'd0);
        check("rst2_no_presc", 8'(presc_clr), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
